// File: rtl/bcd_multi_counter_if.sv
// Control and status bundle for bcd_multi_counter; packed BCD, digit i at [4i+3:4i].
// No handshake: the counter samples inputs every clk edge and never stalls.
interface bcd_multi_counter_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  bit_dir;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   value;
  logic                  tc;
  logic                  ovf;

  modport master (
    output en, bit_dir, load, load_val,
    input  value, tc, ovf
  );

  modport slave (
    input  en, bit_dir, load, load_val,
    output value, tc, ovf
  );
endinterface

// File: rtl/bcd_multi_counter.sv
// Multi-digit BCD up/down counter with load, wrap/saturate and cascade tc; 1-cycle latency.
// No backpressure: a step is taken on every edge with en high; tc is combinational.
module bcd_multi_counter #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  bcd_multi_counter_if.slave ctr
);
  logic [4*DIGITS-1:0] value_q, value_d;
  logic                ovf_q, ovf_d;
  logic [DIGITS:0]     chain;
  logic                at_bound;

  // chain[i] is high when every digit below i sits at the rollover digit for the
  // current direction, so digit i steps this cycle; chain[DIGITS] flags the boundary.
  always_comb begin
    chain[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      chain[i+1] = chain[i] & (ctr.bit_dir ? (value_q[4*i +: 4] == 4'd9)
                                           : (value_q[4*i +: 4] == 4'd0));
    end
  end

  assign at_bound = chain[DIGITS];

  always_comb begin
    value_d = value_q;
    ovf_d   = 1'b0;
    if (ctr.load) begin
      for (int i = 0; i < DIGITS; i++) begin
        value_d[4*i +: 4] = (ctr.load_val[4*i +: 4] > 4'd9) ? 4'd9 : ctr.load_val[4*i +: 4];
      end
    end else if (ctr.en) begin
      ovf_d = at_bound;
      if (!(at_bound && !WRAP)) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (chain[i]) begin
            if (ctr.bit_dir) begin
              value_d[4*i +: 4] = (value_q[4*i +: 4] == 4'd9) ? 4'd0 : value_q[4*i +: 4] + 4'd1;
            end else begin
              value_d[4*i +: 4] = (value_q[4*i +: 4] == 4'd0) ? 4'd9 : value_q[4*i +: 4] - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ctr.value = value_q;
  assign ctr.ovf   = ovf_q;
  assign ctr.tc    = ctr.en & at_bound;
endmodule
